frame_buf_pingpong: RTL and testbench
=====================================

# frame_buf_pingpong

Parametrised two-bank ping-pong frame buffer for the image pipeline, the successor to the single-bank 320x240 RAM. A writer streams one frame of pixels into a free bank with auto-incrementing addresses while a reader drains the oldest completed frame from the other bank with registered, valid-flagged output. Frame-level handshakes (start-of-frame, frame ready, drop reporting) let the sensor-side and display-side engines run without tearing.

## Interface
- DATASIZE, 12, pixel width in bits
- WIDTH, 320, pixels per line
- HEIGHT, 240, lines per frame
- ADDRSIZE, 17, per-bank pointer width; must satisfy 2^ADDRSIZE >= WIDTH*HEIGHT. Storage is 2 x 2^ADDRSIZE words, addressed {bank, ptr}.
- clk  in  1  single clock for all logic and memory
- rst_n  in  1  reset, synchronous, active-low
- wr_sof  in  1  start of write frame; qualifies the same-cycle wr_en as pixel 0
- wr_en  in  1  write pixel strobe
- wdata  in  DATASIZE  write pixel
- rd_sof  in  1  start of read frame
- rd_en  in  1  read pixel request
- rdata  out  DATASIZE  registered read pixel
- rvalid  out  1  rdata valid, one cycle after an accepted rd_en
- rd_last  out  1  high with rvalid on the frame's last pixel
- wr_active  out  1  writer is filling a bank
- rd_active  out  1  reader owns a bank
- frame_ready  out  1  a completed, unread frame is available to rd_sof
- frame_drop  out  1  one-cycle pulse when an incoming frame is dropped
- drop_cnt  out  8  dropped-frame count, saturates at 255

## Operation
- FRAME = WIDTH*HEIGHT. State: full[1:0], newest (bank last completed), writer {IDLE, WRITE} with wb/wr_ptr, reader {IDLE, READ} with rb/rd_ptr. All decisions use registered state from before the edge.
- Writer IDLE + wr_sof: if some bank is not full, select it (if both free, pick the bank != newest), wr_ptr=0, enter WRITE. If both banks are full, the frame is dropped: frame_drop pulses, drop_cnt increments (saturating), writer stays IDLE.
- In WRITE, each wr_en writes wdata to {wb, wr_ptr}, wr_ptr++. A wr_sof+wr_en in the start cycle writes pixel 0.
- Writing pixel FRAME-1 sets full[wb], sets newest=wb, and returns the writer to IDLE. The next frame requires a new wr_sof.
- wr_sof while in WRITE restarts the same bank at pointer 0. The partial frame is discarded and not counted as a drop.
- wr_en while IDLE, or after a dropped wr_sof, is ignored.
- frame_ready = reader IDLE and (full[0] or full[1]).
- Reader IDLE + rd_sof with frame_ready: rb = oldest full bank (the only full one, else the bank != newest), rd_ptr=0, enter READ.
- A same-cycle rd_en reads pixel 0. rd_sof with no frame available is ignored.
- In READ, each rd_en registers mem[{rb, rd_ptr}] into rdata and sets rvalid next cycle, rd_ptr++.
- The rd_en for pixel FRAME-1 clears full[rb] and returns the reader to IDLE. The matching rvalid carries rd_last.
- rd_sof while in READ is ignored. rd_en while IDLE yields no rvalid.
- A writer can never select a full bank, so the bank being read is never overwritten.

## Timing
- Reset (rst_n low at edge): rdata=0, rvalid=0, rd_last=0, wr_active=0, rd_active=0, frame_ready=0, frame_drop=0, drop_cnt=0, full=00, newest=1 (first frame goes to bank 0), both pointers 0. Memory contents are not reset.
- Reset mid-frame aborts both sides. Stored pixels remain but are unreachable.
- Write latency: data is in memory at the edge of wr_en. A same-cycle read of that address by the reader is impossible by construction.
- Read latency: 1 cycle from rd_en to rvalid/rdata. Back-to-back rd_en gives one pixel per cycle.
- Write completion at edge N: frame_ready high in cycle N+1 (if reader IDLE), wr_active low in N+1.
- Read completion at edge N: rd_active low in N+1, full bank freed in N+1. A wr_sof in cycle N still sees the bank full.
- Simultaneous write completion and read release in the same edge: both apply.
- Simultaneous events: wr_sof and rd_sof in the same cycle are independent.

## Test plan
Bench parameters: WIDTH=4, HEIGHT=2, ADDRSIZE=3, FRAME=8.
- Single frame: wr_sof+wr_en with pixels 0x10..0x17 over 8 cycles, then rd_sof+rd_en for 8 cycles -> rdata 0x10..0x17 one cycle after each rd_en, rd_last on 0x17, frame_ready drops at rd_sof.
- Ping-pong: write frame A (0x0A0..), frame B (0x0B0..) with no reads, then read twice -> A then B. A third wr_sof before any read -> frame_drop pulse, drop_cnt=1, third frame data ignored.
- Concurrent: read A while writing C into the released bank after A completes -> no corruption; C reads back after B.
- Restart: wr_sof at pixel 5, then 8 fresh pixels 0x20..0x27 -> frame reads back 0x20..0x27.
- Corner cases: rd_sof with no frame, rd_en while IDLE, wr_en without wr_sof -> no rvalid, no state change. Reset mid-read -> all outputs at reset values next cycle.
- Drop saturation: 260 dropped frames -> drop_cnt stays 255.

Source files
------------

// File: rtl/frame_buf_pingpong.sv
// Two-bank ping-pong frame buffer: writer fills a free bank, reader drains the oldest full bank.
// Writes land at the wr_en edge, read data is valid one cycle after rd_en; frames arriving with both banks full are dropped.
module frame_buf_pingpong #(
  parameter int DATASIZE = 12,
  parameter int WIDTH    = 320,
  parameter int HEIGHT   = 240,
  parameter int ADDRSIZE = 17
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_sof,
  input  logic                wr_en,
  input  logic [DATASIZE-1:0] wdata,
  input  logic                rd_sof,
  input  logic                rd_en,
  output logic [DATASIZE-1:0] rdata,
  output logic                rvalid,
  output logic                rd_last,
  output logic                wr_active,
  output logic                rd_active,
  output logic                frame_ready,
  output logic                frame_drop,
  output logic [7:0]          drop_cnt
);

  localparam int                  FRAME    = WIDTH * HEIGHT;
  localparam logic [ADDRSIZE-1:0] LAST_PTR = ADDRSIZE'(FRAME - 1);

  typedef enum logic {W_IDLE, W_WRITE} wr_state_t;
  typedef enum logic {R_IDLE, R_READ}  rd_state_t;

  logic [DATASIZE-1:0] mem [2**(ADDRSIZE+1)];

  wr_state_t           wr_st;
  rd_state_t           rd_st;
  logic [1:0]          full;
  logic                newest;
  logic                wb, rb;
  logic [ADDRSIZE-1:0] wr_ptr, rd_ptr;

  logic                w_go, w_do, w_done, w_drop, w_sel, w_bank;
  logic [ADDRSIZE-1:0] w_ptr;
  logic                r_go, r_do, r_done, r_sel, r_bank;
  logic [ADDRSIZE-1:0] r_ptr;

  // Effective bank/pointer for this cycle, so a start-of-frame strobe also moves pixel 0.
  always_comb begin
    w_sel  = full[0] ? 1'b1 : (full[1] ? 1'b0 : ~newest);
    w_go   = 1'b0;
    w_drop = 1'b0;
    w_bank = wb;
    w_ptr  = wr_ptr;
    if (wr_st == W_WRITE) begin
      w_go = 1'b1;
      if (wr_sof) w_ptr = '0;
    end else if (wr_sof) begin
      if (&full) begin
        w_drop = 1'b1;
      end else begin
        w_go   = 1'b1;
        w_bank = w_sel;
        w_ptr  = '0;
      end
    end
    w_do   = w_go & wr_en;
    w_done = w_do && (w_ptr == LAST_PTR);
  end

  always_comb begin
    r_sel  = (&full) ? ~newest : full[1];
    r_go   = 1'b0;
    r_bank = rb;
    r_ptr  = rd_ptr;
    if (rd_st == R_READ) begin
      r_go = 1'b1;
    end else if (rd_sof && (|full)) begin
      r_go   = 1'b1;
      r_bank = r_sel;
      r_ptr  = '0;
    end
    r_do   = r_go & rd_en;
    r_done = r_do && (r_ptr == LAST_PTR);
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_do) mem[{w_bank, w_ptr}] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_st      <= W_IDLE;
      rd_st      <= R_IDLE;
      full       <= 2'b00;
      newest     <= 1'b1;
      wb         <= 1'b0;
      rb         <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rdata      <= '0;
      rvalid     <= 1'b0;
      rd_last    <= 1'b0;
      frame_drop <= 1'b0;
      drop_cnt   <= 8'd0;
    end else begin
      wr_st <= (w_go && !w_done) ? W_WRITE : W_IDLE;
      if (w_go) begin
        wb     <= w_bank;
        wr_ptr <= w_done ? '0 : (w_do ? w_ptr + ADDRSIZE'(1) : w_ptr);
      end
      if (w_done) newest <= w_bank;

      rd_st <= (r_go && !r_done) ? R_READ : R_IDLE;
      if (r_go) begin
        rb     <= r_bank;
        rd_ptr <= r_done ? '0 : (r_do ? r_ptr + ADDRSIZE'(1) : r_ptr);
      end

      // Writer and reader always own different banks, so set and clear never collide.
      full <= (full | ({1'b0, w_done} << w_bank)) & ~({1'b0, r_done} << r_bank);

      rvalid  <= r_do;
      rd_last <= r_done;
      if (r_do) rdata <= mem[{r_bank, r_ptr}];

      frame_drop <= w_drop;
      if (w_drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign wr_active   = (wr_st == W_WRITE);
  assign rd_active   = (rd_st == R_READ);
  assign frame_ready = (rd_st == R_IDLE) && (|full);

endmodule

// File: tb/tb_frame_buf_pingpong.sv
// Randomised and directed bench for frame_buf_pingpong against a frame-queue reference model.
module tb_frame_buf_pingpong;
  localparam int DW    = 12;
  localparam int FRAME = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0, wr_sof = 1'b0, wr_en = 1'b0, rd_sof = 1'b0, rd_en = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          rvalid, rd_last, wr_active, rd_active, frame_ready, frame_drop;
  logic [7:0]    drop_cnt;

  always #5 clk = ~clk;

  frame_buf_pingpong #(.DATASIZE(DW), .WIDTH(4), .HEIGHT(2), .ADDRSIZE(3)) dut (
    .clk(clk), .rst_n(rst_n), .wr_sof(wr_sof), .wr_en(wr_en), .wdata(wdata),
    .rd_sof(rd_sof), .rd_en(rd_en), .rdata(rdata), .rvalid(rvalid), .rd_last(rd_last),
    .wr_active(wr_active), .rd_active(rd_active), .frame_ready(frame_ready),
    .frame_drop(frame_drop), .drop_cnt(drop_cnt)
  );

  // Reference model: completed frames queue up oldest-first; at most two frames occupy storage.
  typedef logic [FRAME*DW-1:0] frame_t;
  typedef struct packed { logic [DW-1:0] d; logic last; } rexp_t;

  frame_t        stored[$];
  logic [DW-1:0] wq[$];
  rexp_t         rq[$];
  frame_t        cur;
  bit            writing, reading, m_drop, m_rst;
  int            ridx, m_cnt;
  int            checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int     occ;
    frame_t f;
    if (!rst_n) begin
      stored.delete(); wq.delete(); rq.delete();
      writing = 0; reading = 0; ridx = 0; m_drop = 0; m_cnt = 0; m_rst = 1;
      return;
    end
    m_rst  = 0;
    m_drop = 0;
    occ    = stored.size() + (reading ? 1 : 0);
    if (!reading && rd_sof && stored.size() > 0) begin
      cur = stored.pop_front(); reading = 1; ridx = 0;
    end
    if (reading && rd_en) begin
      rq.push_back('{cur[ridx*DW +: DW], (ridx == FRAME-1)});
      ridx++;
      if (ridx == FRAME) reading = 0;
    end
    if (wr_sof) begin
      if (writing) wq.delete();
      else if (occ < 2) begin writing = 1; wq.delete(); end
      else begin m_drop = 1; if (m_cnt < 255) m_cnt++; end
    end
    if (writing && wr_en) begin
      wq.push_back(wdata);
      if (wq.size() == FRAME) begin
        for (int i = 0; i < FRAME; i++) f[i*DW +: DW] = wq[i];
        stored.push_back(f);
        writing = 0;
        wq.delete();
      end
    end
  endtask

  task automatic step(input logic rs_n, input logic ws, input logic we, input logic [DW-1:0] wd,
                      input logic rs, input logic re);
    rst_n = rs_n; wr_sof = ws; wr_en = we; wdata = wd; rd_sof = rs; rd_en = re;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic write_frame(input logic [DW-1:0] base);
    for (int i = 0; i < FRAME; i++) step(1, i == 0, 1, base + DW'(i), 0, 0);
  endtask

  task automatic read_frame();
    for (int i = 0; i < FRAME; i++) step(1, 0, 0, '0, i == 0, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, '0, 0, 0);
  endtask

  // Monitor: pops one expected pixel per rvalid and compares frame-level status every cycle.
  initial begin
    rexp_t e;
    forever begin
      @(negedge clk);
      if (rvalid) begin
        if (rq.size() == 0) chk("rvalid_spurious", rvalid, 0);
        else begin
          e = rq.pop_front();
          chk("rdata", rdata, e.d);
          chk("rd_last", rd_last, e.last);
        end
      end else if (rq.size() != 0) begin
        chk("rvalid_missing", rvalid, 1);
        rq.delete();
      end
      chk("frame_ready", frame_ready, !reading && stored.size() > 0);
      chk("wr_active", wr_active, writing);
      chk("rd_active", rd_active, reading);
      chk("frame_drop", frame_drop, m_drop);
      chk("drop_cnt", drop_cnt, m_cnt);
      if (m_rst) begin
        chk("rst_rdata", rdata, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rd_last", rd_last, 0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    step(0, 0, 0, '0, 0, 0);
    step(0, 0, 0, '0, 0, 0);
    idle(2);

    // Single frame
    write_frame(12'h010);
    idle(1);
    read_frame();
    idle(2);

    // Ping-pong with a dropped third frame
    write_frame(12'h0A0);
    write_frame(12'h0B0);
    write_frame(12'h0C0);
    idle(2);
    read_frame();
    read_frame();
    idle(2);

    // Concurrent: C written into A's bank while B drains
    write_frame(12'h1A0);
    write_frame(12'h1B0);
    read_frame();
    for (int i = 0; i < FRAME; i++) step(1, i == 0, 1, 12'h1C0 + DW'(i), i == 0, 1);
    read_frame();
    idle(2);

    // Restart mid-frame
    for (int i = 0; i < 5; i++) step(1, i == 0, 1, 12'h030 + DW'(i), 0, 0);
    write_frame(12'h020);
    read_frame();
    idle(2);

    // Corner cases
    step(1, 0, 0, '0, 1, 0);
    step(1, 0, 0, '0, 0, 1);
    step(1, 0, 0, '0, 1, 1);
    for (int i = 0; i < FRAME; i++) step(1, 0, 1, 12'h0EE, 0, 0);
    idle(2);

    // Reset mid-read
    write_frame(12'h050);
    for (int i = 0; i < 3; i++) step(1, 0, 0, '0, i == 0, 1);
    step(0, 0, 1, 12'h055, 0, 1);
    idle(3);

    // Drop saturation
    write_frame(12'h060);
    write_frame(12'h070);
    for (int i = 0; i < 260; i++) step(1, 1, 1, 12'h0FF, 0, 0);
    idle(2);
    read_frame();
    step(0, 0, 0, '0, 0, 0);
    idle(2);

    // Random traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 599) != 0, $urandom_range(0, 11) == 0, $urandom_range(0, 3) != 0,
           DW'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);

    idle(3);
    chk("scoreboard_drained", rq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
